fp_div_norm_round: RTL and testbench

Downstream stage of the integer mantissa divider in the FP divide path. It consumes the raw mantissa quotient and remainder plus the pre-computed sign, exponent and special-case flags. It normalizes, rounds, range-checks the exponent and packs an IEEE-754 result with exception flags. It is a 2-stage pipeline with a valid/ready handshake on both sides.

---
 rtl/fp_div_norm_round_if.sv | 39 +++
 rtl/fp_div_norm_round.sv | 95 +++++++++
 tb/tb_fp_div_norm_round.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_norm_round_if.sv
// fp_div_norm_round_if: input/output handshake bundle of the FP divide normalize/round stage (rm only with FDIV_RMODE_EN)
interface fp_div_norm_round_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   s_in;
    logic [EXP_W+1:0]       e_in;
    logic [MAN_W+2:0]       q_in;
    logic [MAN_W+2:0]       r_in;
    logic                   nan_in;
    logic                   inf_in;
    logic                   zero_in;
    logic                   dz_in;
`ifdef FDIV_RMODE_EN
    logic [1:0]             rm;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   z_out;
    logic [3:0]             flags_out;

    modport master (
`ifdef FDIV_RMODE_EN
        output rm,
`endif
        output in_valid, s_in, e_in, q_in, r_in, nan_in, inf_in, zero_in, dz_in, out_ready,
        input  in_ready, out_valid, z_out, flags_out
    );

    modport slave (
`ifdef FDIV_RMODE_EN
        input  rm,
`endif
        input  in_valid, s_in, e_in, q_in, r_in, nan_in, inf_in, zero_in, dz_in, out_ready,
        output in_ready, out_valid, z_out, flags_out
    );
endinterface

// File: rtl/fp_div_norm_round.sv
// fp_div_norm_round: 2-stage normalize/round/pack of the FP divide quotient; FDIV_RMODE_EN adds rm[1:0] rounding modes
module fp_div_norm_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic                 clk,
    input logic                 rst,
    fp_div_norm_round_if.slave  bus
);
    logic                   en;
    logic                   top, guard, sticky, inc, carry;
    logic [MAN_W-1:0]       frac, frac_r;
    logic [EXP_W+1:0]       exp_n, exp_r;
    logic                   v1, s1, ix1, nan1, inf1, zero1, dz1;
    logic [EXP_W+1:0]       e1;
    logic [MAN_W-1:0]       f1;
    logic                   ovf, unf, sat;
    logic [EXP_W+MAN_W:0]   inf_pat, max_pat, zero_pat, z_n;
    logic [3:0]             f_n;
`ifdef FDIV_RMODE_EN
    logic [1:0]             rm1;
`endif

    assign en = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = en;

    always_comb begin
        top    = bus.q_in[MAN_W+2];
        frac   = top ? bus.q_in[MAN_W+1:2] : bus.q_in[MAN_W:1];
        guard  = top ? bus.q_in[1] : bus.q_in[0];
        sticky = (top & bus.q_in[0]) | (|bus.r_in);
        exp_n  = top ? bus.e_in : bus.e_in - 1'b1;
`ifdef FDIV_RMODE_EN
        inc = bus.rm == 2'b01 ? 1'b0 :
              bus.rm == 2'b10 ? (guard | sticky) & bus.s_in :
              bus.rm == 2'b11 ? (guard | sticky) & ~bus.s_in :
              guard & (sticky | frac[0]);
`else
        inc = guard & (sticky | frac[0]);
`endif
        {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
        exp_r = exp_n + {{(EXP_W+1){1'b0}}, carry};
    end

    // Exponent is two's complement: negative or zero flushes, >= all-ones saturates.
    always_comb begin
        unf = e1[EXP_W+1] | (e1 == '0);
        ovf = ~e1[EXP_W+1] & (e1[EXP_W] | (&e1[EXP_W-1:0]));
`ifdef FDIV_RMODE_EN
        sat = (rm1 == 2'b01) | ((rm1 == 2'b10) & ~s1) | ((rm1 == 2'b11) & s1);
`else
        sat = 1'b0;
`endif
        inf_pat  = {s1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        max_pat  = {s1, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        zero_pat = {s1, {(EXP_W+MAN_W){1'b0}}};
        z_n = nan1            ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
              (inf1 | dz1)    ? inf_pat :
              zero1           ? zero_pat :
              ovf             ? (sat ? max_pat : inf_pat) :
              unf             ? zero_pat :
              {s1, e1[EXP_W-1:0], f1};
        f_n = nan1            ? 4'b0000 :
              (inf1 | dz1)    ? {3'b000, dz1} :
              zero1           ? 4'b0000 :
              ovf             ? 4'b1100 :
              unf             ? 4'b1010 :
              {ix1, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.z_out     <= '0;
            bus.flags_out <= '0;
        end else if (en) begin
            v1            <= bus.in_valid;
            s1            <= bus.s_in;
            e1            <= exp_r;
            f1            <= frac_r;
            ix1           <= guard | sticky;
            nan1          <= bus.nan_in;
            inf1          <= bus.inf_in;
            zero1         <= bus.zero_in;
            dz1           <= bus.dz_in;
`ifdef FDIV_RMODE_EN
            rm1           <= bus.rm;
`endif
            bus.out_valid <= v1;
            bus.z_out     <= z_n;
            bus.flags_out <= f_n;
        end
    end
endmodule

// File: tb/tb_fp_div_norm_round.sv
// tb_fp_div_norm_round: directed table, backpressure/reset sequences and random beats against an arithmetic model
module tb_fp_div_norm_round;
    typedef struct {
        bit         s;
        logic [9:0] e;
        logic [25:0] q;
        logic [25:0] r;
        bit nan, inf, zero, dz;
        logic [1:0] rm;
    } beat_t;
    typedef struct {
        logic [31:0] z;
        logic [3:0]  f;
    } res_t;
    typedef struct {
        beat_t b;
        res_t  x;
        bit    rmode_only;
    } vec_t;

    logic clk, rst;
    int tests = 0, fails = 0;
    bit bp_rand = 0, ready_force = 1, rnd = 1;
    res_t exq[$];
    vec_t vt[$];

    fp_div_norm_round_if #(.EXP_W(8), .MAN_W(23)) bus ();
    fp_div_norm_round #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rnd <= ($urandom_range(0, 3) != 0);
    assign bus.out_ready = bp_rand ? rnd : ready_force;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact rounding of the integer quotient, then IEEE range/special rules.
    function automatic res_t model(input beat_t b);
        res_t o;
        int ex, sh;
        longint qq, m, rb, half;
        bit ix, up, sat;
        qq = longint'(b.q);
        sh = b.q[25] ? 2 : 1;
        ex = $signed(b.e);
        ex = ex - (b.q[25] ? 0 : 1);
        m = qq >> sh;
        rb = qq - (m << sh);
        half = longint'(1) << (sh - 1);
        ix = (rb != 0) || (b.r != 0);
        case (b.rm)
            2'b01:   up = 0;
            2'b10:   up = ix && b.s;
            2'b11:   up = ix && !b.s;
            default: up = (rb > half) || (rb == half && (b.r != 0 || m[0]));
        endcase
        m = m + longint'(up);
        if (m == (longint'(1) << 24)) begin
            m = m >> 1;
            ex++;
        end
        sat = (b.rm == 2'b01) || (b.rm == 2'b10 && !b.s) || (b.rm == 2'b11 && b.s);
        if (b.nan) begin
            o.z = 32'h7FC00000; o.f = 4'b0000;
        end else if (b.inf || b.dz) begin
            o.z = {b.s, 8'hFF, 23'h0}; o.f = {3'b000, b.dz};
        end else if (b.zero) begin
            o.z = {b.s, 31'h0}; o.f = 4'b0000;
        end else if (ex >= 255) begin
            o.z = sat ? {b.s, 8'hFE, 23'h7FFFFF} : {b.s, 8'hFF, 23'h0}; o.f = 4'b1100;
        end else if (ex <= 0) begin
            o.z = {b.s, 31'h0}; o.f = 4'b1010;
        end else begin
            o.z = {b.s, 8'(ex), 23'(m)}; o.f = {ix, 3'b000};
        end
        return o;
    endfunction

    always @(negedge clk) begin
        beat_t b;
        res_t  x;
        if (!rst) exq.delete();
        else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: got z=%0h with no beat pending", bus.z_out);
                end else begin
                    x = exq.pop_front();
                    chk("model_z", 64'(bus.z_out), 64'(x.z));
                    chk("model_flags", 64'(bus.flags_out), 64'(x.f));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                b.s = bus.s_in; b.e = bus.e_in; b.q = bus.q_in; b.r = bus.r_in;
                b.nan = bus.nan_in; b.inf = bus.inf_in; b.zero = bus.zero_in; b.dz = bus.dz_in;
`ifdef FDIV_RMODE_EN
                b.rm = bus.rm;
`else
                b.rm = 2'b00;
`endif
                exq.push_back(model(b));
            end
        end
    end

    task automatic drive(input beat_t b);
        bus.s_in = b.s; bus.e_in = b.e; bus.q_in = b.q; bus.r_in = b.r;
        bus.nan_in = b.nan; bus.inf_in = b.inf; bus.zero_in = b.zero; bus.dz_in = b.dz;
`ifdef FDIV_RMODE_EN
        bus.rm = b.rm;
`endif
        bus.in_valid = 1;
    endtask

    task automatic send(input beat_t b);
        int n = 0;
        bit acc = 0;
        drive(b);
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 64'(acc), 64'(1));
        bus.in_valid = 0;
    endtask

    function automatic beat_t mk(input bit s, input int e, input logic [25:0] q, input logic [25:0] r,
                                 input bit nan, input bit inf, input bit zero, input bit dz, input logic [1:0] rm);
        beat_t b;
        b.s = s; b.e = 10'(e); b.q = q; b.r = r;
        b.nan = nan; b.inf = inf; b.zero = zero; b.dz = dz; b.rm = rm;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b = mk($urandom_range(0, 1), int'($urandom_range(0, 320)) - 20, 26'($urandom_range(32'h1000000, 32'h3FFFFFF)),
               ($urandom_range(0, 1) != 0) ? 26'($urandom) : 26'(0),
               $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
               $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, 2'b00);
`ifdef FDIV_RMODE_EN
        b.rm = 2'($urandom_range(0, 3));
`endif
        return b;
    endfunction

    initial begin
        beat_t a, bb, c;
        res_t ra;
        int stale;
        vt.push_back('{mk(0, 128, 26'h2000000, 0, 0, 0, 0, 0, 0), '{32'h40000000, 4'b0000}, 0});
        vt.push_back('{mk(0, 126, 26'h1555555, 1, 0, 0, 0, 0, 0), '{32'h3EAAAAAB, 4'b1000}, 0});
        vt.push_back('{mk(1, 300, 26'h2000000, 0, 0, 0, 0, 0, 0), '{32'hFF800000, 4'b1100}, 0});
        vt.push_back('{mk(1, 300, 26'h2000000, 0, 0, 0, 0, 0, 1), '{32'hFF7FFFFF, 4'b1100}, 1});
        vt.push_back('{mk(1, 0, 26'h2000000, 0, 0, 0, 0, 0, 0), '{32'h80000000, 4'b1010}, 0});
        vt.push_back('{mk(1, 128, 26'h2000000, 0, 1, 1, 1, 1, 0), '{32'h7FC00000, 4'b0000}, 0});
        vt.push_back('{mk(0, 5, 26'h0, 0, 0, 0, 1, 1, 0), '{32'h7F800000, 4'b0001}, 0});
        vt.push_back('{mk(1, 5, 26'h0, 0, 0, 1, 1, 0, 0), '{32'hFF800000, 4'b0000}, 0});
        vt.push_back('{mk(1, 5, 26'h0, 0, 0, 0, 1, 0, 0), '{32'h80000000, 4'b0000}, 0});
        vt.push_back('{mk(0, 127, 26'h3FFFFFF, 0, 0, 0, 0, 0, 0), '{32'h40000000, 4'b1000}, 0});
        vt.push_back('{mk(0, 127, 26'h2000002, 0, 0, 0, 0, 0, 0), '{32'h3F800000, 4'b1000}, 0});
        vt.push_back('{mk(0, 127, 26'h2000006, 0, 0, 0, 0, 0, 0), '{32'h3F800002, 4'b1000}, 0});
        vt.push_back('{mk(0, 254, 26'h2000000, 0, 0, 0, 0, 0, 0), '{32'h7F000000, 4'b0000}, 0});
        vt.push_back('{mk(0, 255, 26'h2000000, 0, 0, 0, 0, 0, 0), '{32'h7F800000, 4'b1100}, 0});
        vt.push_back('{mk(0, 1, 26'h1000000, 0, 0, 0, 0, 0, 0), '{32'h00000000, 4'b1010}, 0});
        vt.push_back('{mk(1, -5, 26'h2000000, 0, 0, 0, 0, 0, 0), '{32'h80000000, 4'b1010}, 0});

        rst = 0;
        bus.in_valid = 0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 0);
        chk("reset_z", 64'(bus.z_out), 0);
        chk("reset_flags", 64'(bus.flags_out), 0);
        @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
`ifndef FDIV_RMODE_EN
            if (vt[i].rmode_only) continue;
`endif
            send(vt[i].b);
            @(negedge clk);
            chk($sformatf("lat1_valid_v%0d", i), 64'(bus.out_valid), 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("lat2_valid_v%0d", i), 64'(bus.out_valid), 1);
            chk($sformatf("z_v%0d", i), 64'(bus.z_out), 64'(vt[i].x.z));
            chk($sformatf("flags_v%0d", i), 64'(bus.flags_out), 64'(vt[i].x.f));
            @(posedge clk);
            #1;
        end

        // Backpressure: two beats fill the pipe, the third must stall.
        a  = mk(0, 128, 26'h2000000, 0, 0, 0, 0, 0, 0);
        bb = mk(0, 126, 26'h1555555, 3, 0, 0, 0, 0, 0);
        c  = mk(1, 130, 26'h3000000, 0, 0, 0, 0, 0, 0);
        ra = model(a);
        ready_force = 0;
        send(a);
        send(bb);
        drive(c);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(bus.in_ready), 0);
        chk("bp_out_valid", 64'(bus.out_valid), 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("bp_hold_z_%0d", k), 64'(bus.z_out), 64'(ra.z));
        end
        ready_force = 1;
        send(c);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 64'(exq.size()), 0);

        // Reset with two beats in flight.
        send(a);
        send(bb);
        rst = 0;
        @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 0);
        chk("midrst_z", 64'(bus.z_out), 0);
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("midrst_no_stale", 64'(stale), 0);
        @(posedge clk);
        #1;

        bp_rand = 1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(rand_beat());
        end
        bp_rand = 0;
        for (int k = 0; k < 100 && exq.size() != 0; k++) @(posedge clk);
        #1;
        chk("final_drain", 64'(exq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
